// File: rtl/dncnt_timer.sv
// Two-stage loadable down-counter timer: a prescaler feeding a divider, each
// with its own reload register, one-shot / auto-reload modes and a cascadable borrow.
module dncnt_timer #(
  parameter int PRE_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resl,
  input  logic [PRE_W-1:0] pre_d,
  input  logic             pre_ld,
  input  logic [DIV_W-1:0] div_d,
  input  logic             div_ld,
  input  logic             ci,
  input  logic             mode,
  output logic [PRE_W-1:0] pre_q,
  output logic [DIV_W-1:0] div_q,
  output logic             run,
  output logic             co,
  output logic             tick
);

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_rel;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_rel;
  logic             run_r;
  logic             tick_r;

  logic step;
  logic pre_uf;
  logic div_uf;

  // A zero count always reloads instead of decrementing, so nothing ever wraps.
  always_comb begin
    step   = run_r & ci;
    pre_uf = step & (pre_cnt == '0);
    div_uf = pre_uf & (div_cnt == '0);
  end

  // Prescaler: a load wins over underflow reload, which wins over decrement.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      pre_cnt <= '0;
      pre_rel <= '0;
    end else if (pre_ld) begin
      pre_rel <= pre_d;
      pre_cnt <= pre_d;
    end else if (pre_uf) begin
      pre_cnt <= pre_rel;
    end else if (step) begin
      pre_cnt <= pre_cnt - PRE_ONE;
    end
  end

  // Divider and armed flag; mode is only consulted at the moment of underflow.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      div_cnt <= '0;
      div_rel <= '0;
      run_r   <= 1'b0;
    end else if (div_ld) begin
      div_rel <= div_d;
      div_cnt <= div_d;
      run_r   <= 1'b1;
    end else if (div_uf) begin
      div_cnt <= div_rel;
      if (!mode) run_r <= 1'b0;
    end else if (pre_uf) begin
      div_cnt <= div_cnt - DIV_ONE;
    end
  end

  // Any load in the underflow cycle cancels the interrupt pulse.
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) tick_r <= 1'b0;
    else       tick_r <= div_uf & ~div_ld & ~pre_ld;
  end

  always_comb begin
    pre_q = pre_cnt;
    div_q = div_cnt;
    run   = run_r;
    co    = div_uf;
    tick  = tick_r;
  end

endmodule

// File: tb/tb_dncnt_timer.sv
// Directed bench for dncnt_timer: each step drives inputs, advances the clock
// and compares outputs with hand-computed values.
module tb_dncnt_timer;

  localparam int PRE_W = 16;
  localparam int DIV_W = 16;

  logic             clk;
  logic             resl;
  logic [PRE_W-1:0] pre_d;
  logic             pre_ld;
  logic [DIV_W-1:0] div_d;
  logic             div_ld;
  logic             ci;
  logic             mode;
  logic [PRE_W-1:0] pre_q;
  logic [DIV_W-1:0] div_q;
  logic             run;
  logic             co;
  logic             tick;

  int vectors = 0;
  int fails   = 0;

  dncnt_timer #(.PRE_W(PRE_W), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .resl   (resl),
    .pre_d  (pre_d),
    .pre_ld (pre_ld),
    .div_d  (div_d),
    .div_ld (div_ld),
    .ci     (ci),
    .mode   (mode),
    .pre_q  (pre_q),
    .div_q  (div_q),
    .run    (run),
    .co     (co),
    .tick   (tick)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Load both stages in one cycle
  task automatic load_both(input logic [PRE_W-1:0] p, input logic [DIV_W-1:0] d);
    pre_d  = p;
    div_d  = d;
    pre_ld = 1'b1;
    div_ld = 1'b1;
    step_clk();
    pre_ld = 1'b0;
    div_ld = 1'b0;
  endtask

  initial begin
    resl   = 1'b0;
    pre_d  = '0;
    pre_ld = 1'b0;
    div_d  = '0;
    div_ld = 1'b0;
    ci     = 1'b1;
    mode   = 1'b1;

    // Reset state
    #1;
    chk("rst_pre_q", 32'(pre_q), 0);
    chk("rst_div_q", 32'(div_q), 0);
    chk("rst_run",   32'(run),   0);
    chk("rst_co",    32'(co),    0);
    chk("rst_tick",  32'(tick),  0);
    step_clk();
    resl = 1'b1;
    step_clk();
    chk("idle_run", 32'(run), 0);

    // Auto-reload, pre=2 div=3: tick every 12 cycles
    mode = 1'b1;
    ci   = 1'b1;
    load_both(16'd2, 16'd3);
    chk("ar_load_pre", 32'(pre_q), 2);
    chk("ar_load_div", 32'(div_q), 3);
    chk("ar_load_run", 32'(run),   1);
    for (int n = 1; n <= 30; n++) begin
      step_clk();
      chk("ar_tick", 32'(tick),  (n % 12 == 0) ? 1 : 0);
      chk("ar_co",   32'(co),    (n % 12 == 11) ? 1 : 0);
      chk("ar_pre",  32'(pre_q), 2 - (n % 3));
      chk("ar_div",  32'(div_q), 3 - ((n % 12) / 3));
    end

    // One-shot, pre=0 div=4: single tick 5 cycles after load
    mode = 1'b0;
    load_both(16'd0, 16'd4);
    chk("os_load_run", 32'(run), 1);
    for (int n = 1; n <= 8; n++) begin
      step_clk();
      chk("os_tick", 32'(tick),  (n == 5) ? 1 : 0);
      chk("os_run",  32'(run),   (n < 5) ? 1 : 0);
      chk("os_div",  32'(div_q), (n < 5) ? 4 - n : 4);
      chk("os_pre",  32'(pre_q), 0);
      chk("os_co",   32'(co),    (n == 4) ? 1 : 0);
    end
    // Re-arm with div_ld alone
    div_d  = 16'd4;
    div_ld = 1'b1;
    step_clk();
    div_ld = 1'b0;
    chk("os_rearm_run", 32'(run), 1);
    for (int n = 1; n <= 6; n++) begin
      step_clk();
      chk("os2_tick", 32'(tick), (n == 5) ? 1 : 0);
      chk("os2_run",  32'(run),  (n < 5) ? 1 : 0);
    end

    // ci toggling, pre=1 div=1: period stretches from 4 to 8
    mode = 1'b1;
    load_both(16'd1, 16'd1);
    for (int n = 0; n < 24; n++) begin
      ci = (n % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      chk("ci_co", 32'(co), (n % 8 == 6) ? 1 : 0);
      step_clk();
      chk("ci_tick", 32'(tick), (n % 8 == 6) ? 1 : 0);
    end
    ci = 1'b1;

    // div_ld in the co cycle: tick suppressed, new value taken
    load_both(16'd2, 16'd3);
    for (int n = 1; n <= 11; n++) step_clk();
    chk("col_co", 32'(co), 1);
    div_d  = 16'd1;
    div_ld = 1'b1;
    step_clk();
    div_ld = 1'b0;
    chk("col_tick", 32'(tick),  0);
    chk("col_div",  32'(div_q), 1);
    chk("col_pre",  32'(pre_q), 2);
    chk("col_run",  32'(run),   1);
    for (int n = 13; n <= 18; n++) begin
      step_clk();
      chk("col_next_tick", 32'(tick), (n == 18) ? 1 : 0);
    end
    chk("col_reload_div", 32'(div_q), 1);
    chk("col_reload_pre", 32'(pre_q), 2);

    // Both reloads zero: co and tick every cycle
    load_both(16'd0, 16'd0);
    for (int n = 1; n <= 6; n++) begin
      step_clk();
      chk("z_co",   32'(co),    1);
      chk("z_tick", 32'(tick),  1);
      chk("z_pre",  32'(pre_q), 0);
      chk("z_div",  32'(div_q), 0);
    end
    // Reset drops a tick in flight immediately
    resl = 1'b0;
    #1;
    chk("z_rst_tick", 32'(tick), 0);
    chk("z_rst_co",   32'(co),   0);
    #2;
    resl = 1'b1;
    step_clk();

    // Reset mid-count at pre=5 div=7
    load_both(16'd5, 16'd7);
    chk("mr_pre", 32'(pre_q), 5);
    chk("mr_div", 32'(div_q), 7);
    resl = 1'b0;
    #2;
    chk("mr_rst_pre",  32'(pre_q), 0);
    chk("mr_rst_div",  32'(div_q), 0);
    chk("mr_rst_run",  32'(run),   0);
    chk("mr_rst_tick", 32'(tick),  0);
    #2;
    resl = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step_clk();
      chk("mr_idle_run",  32'(run),   0);
      chk("mr_idle_div",  32'(div_q), 0);
      chk("mr_idle_tick", 32'(tick),  0);
    end
    // pre_ld accepted while idle, counters stay frozen
    pre_d  = 16'd3;
    pre_ld = 1'b1;
    step_clk();
    pre_ld = 1'b0;
    chk("idle_preld_pre", 32'(pre_q), 3);
    chk("idle_preld_run", 32'(run),   0);
    step_clk();
    step_clk();
    chk("idle_frozen_pre", 32'(pre_q), 3);
    // div_ld re-arms
    div_d  = 16'd2;
    div_ld = 1'b1;
    step_clk();
    div_ld = 1'b0;
    chk("rearm_run", 32'(run),   1);
    chk("rearm_div", 32'(div_q), 2);
    step_clk();
    chk("rearm_pre_dec", 32'(pre_q), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
